// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg -- shared types and constants for the memory stage.
//   state_t : IDLE / ACCESS / DONE sequencing of one memory instruction
//   op_t    : decoded memory operation (OP_NONE = pass-through)
//   word_t  : which field a single 16-bit memory beat carries
//   MEM_*   : bit positions inside the i_Mem control field
//   ADDR_W  : data-memory / stack-pointer width, SP_RESET : SP after reset
package mem_stage_pkg;

  localparam int ADDR_W = 20;
  localparam logic [ADDR_W-1:0] SP_RESET = 20'hFFFFF;
  localparam logic [ADDR_W-1:0] SP_ONE   = 20'h00001;

  localparam int MEM_READ  = 0;
  localparam int MEM_WRITE = 1;
  localparam int MEM_PUSH  = 2;
  localparam int MEM_POP   = 3;
  localparam int MEM_PC    = 4;
  localparam int MEM_FLAGS = 5;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  typedef enum logic [2:0] {OP_NONE, OP_READ, OP_WRITE, OP_PUSH, OP_POP} op_t;
  typedef enum logic [1:0] {W_DATA, W_PC_HI, W_PC_LO, W_FLAG} word_t;

  // One operation per instruction, highest priority first.
  function automatic op_t decode_op(input logic [5:0] mem);
    op_t op;
    op = OP_NONE;
    if (mem[MEM_PUSH])       op = OP_PUSH;
    else if (mem[MEM_POP])   op = OP_POP;
    else if (mem[MEM_WRITE]) op = OP_WRITE;
    else if (mem[MEM_READ])  op = OP_READ;
    return op;
  endfunction

  // Beats per instruction; the flags bit only counts together with the pc bit.
  function automatic logic [1:0] word_count(input op_t op, input logic [5:0] mem);
    logic [1:0] n;
    n = 2'd1;
    if ((op == OP_PUSH || op == OP_POP) && mem[MEM_PC])
      n = mem[MEM_FLAGS] ? 2'd3 : 2'd2;
    return n;
  endfunction

endpackage

// File: rtl/mem_stage_stack_ptr.sv
// stack_ptr -- 20-bit stack pointer register with modulo-2^20 step logic.
//   clk, rst      : clock, asynchronous active-low reset (value -> SP_RESET)
//   inc, dec      : step up / down by one this cycle (inc wins if both)
//   value         : current stack pointer
//   value_up      : value + 1, used as the pre-incremented pop address
module stack_ptr
  import mem_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              dec,
  output logic [ADDR_W-1:0] value,
  output logic [ADDR_W-1:0] value_up
);

  // Natural 20-bit wrap gives FFFFF+1=00000 and 00000-1=FFFFF.
  assign value_up = value + SP_ONE;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      value <= SP_RESET;
    else if (inc)
      value <= value_up;
    else if (dec)
      value <= value - SP_ONE;
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage -- pipeline memory stage: read/write/push/pop, multi-word pc/flags
// stack transfers over a ready-handshaked 16-bit data-memory port.
//   clk, rst (async active-low)
//   i_valid, i_Mem, i_WB, i_Rdst, i_pc, i_alu, i_read_data1, i_flag : ALU/MEM buffer
//   mem_req, mem_we, mem_addr, mem_wdata, mem_rdata, mem_ready      : data memory
//   stall : holds the upstream buffer while an access is pending
//   o_valid, o_WB, o_Rdst, o_alu, o_mem_data                        : to writeback
//   o_new_pc/o_pc_load, o_flag/o_flag_load : one-cycle restore pulses from pops
//   o_sp : current stack pointer
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  input  logic [5:0]        i_Mem,
  input  logic [3:0]        i_WB,
  input  logic [2:0]        i_Rdst,
  input  logic [31:0]       i_pc,
  input  logic [15:0]       i_alu,
  input  logic [15:0]       i_read_data1,
  input  logic [3:0]        i_flag,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_ready,
  output logic              stall,
  output logic              o_valid,
  output logic [3:0]        o_WB,
  output logic [2:0]        o_Rdst,
  output logic [15:0]       o_alu,
  output logic [15:0]       o_mem_data,
  output logic [31:0]       o_new_pc,
  output logic              o_pc_load,
  output logic [3:0]        o_flag,
  output logic              o_flag_load,
  output logic [ADDR_W-1:0] o_sp
);

  state_t      state_reg;
  op_t         op_reg;
  logic [1:0]  k_reg, n_reg;
  logic        pc_op_reg, flags_op_reg, pt_valid_reg;
  logic [3:0]  wb_reg, flag_in_reg, flag_out_reg;
  logic [2:0]  rdst_reg;
  logic [31:0] pc_reg, new_pc_reg;
  logic [15:0] alu_reg, rd1_reg, mem_data_reg;

  op_t               cur_op;
  word_t             word;
  logic              accept_mem, beat_done, last_beat, sp_inc, sp_dec;
  logic [ADDR_W-1:0] sp, sp_up;

  stack_ptr u_sp (
    .clk      (clk),
    .rst      (rst),
    .inc      (sp_inc),
    .dec      (sp_dec),
    .value    (sp),
    .value_up (sp_up)
  );

  always_comb begin
    cur_op     = decode_op(i_Mem);
    accept_mem = (state_reg == IDLE) && i_valid && (cur_op != OP_NONE);
    // Gated by rst so the buffer is released the instant reset is applied.
    stall      = rst && ((state_reg == ACCESS) || accept_mem);
    mem_req    = (state_reg == ACCESS);
    beat_done  = mem_req && mem_ready;
    last_beat  = (k_reg == n_reg - 2'd1);
    sp_dec     = beat_done && (op_reg == OP_PUSH);
    sp_inc     = beat_done && (op_reg == OP_POP);

    // Push stores hi, lo, flags going down; pop retrieves them in reverse.
    word = W_DATA;
    if (pc_op_reg) begin
      if (op_reg == OP_PUSH)
        word = (k_reg == 2'd0) ? W_PC_HI : (k_reg == 2'd1) ? W_PC_LO : W_FLAG;
      else if (flags_op_reg)
        word = (k_reg == 2'd0) ? W_FLAG : (k_reg == 2'd1) ? W_PC_LO : W_PC_HI;
      else
        word = (k_reg == 2'd0) ? W_PC_LO : W_PC_HI;
    end

    mem_addr = '0;
    if (mem_req) begin
      case (op_reg)
        OP_PUSH: mem_addr = sp;
        OP_POP:  mem_addr = sp_up;
        default: mem_addr = {4'b0, alu_reg};
      endcase
    end

    mem_we    = mem_req && (op_reg == OP_WRITE || op_reg == OP_PUSH);
    mem_wdata = '0;
    if (mem_we) begin
      case (word)
        W_PC_HI: mem_wdata = pc_reg[31:16];
        W_PC_LO: mem_wdata = pc_reg[15:0];
        W_FLAG:  mem_wdata = {12'b0, flag_in_reg};
        default: mem_wdata = rd1_reg;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      op_reg       <= OP_NONE;
      k_reg        <= '0;
      n_reg        <= '0;
      pc_op_reg    <= 1'b0;
      flags_op_reg <= 1'b0;
      pt_valid_reg <= 1'b0;
      wb_reg       <= '0;
      rdst_reg     <= '0;
      alu_reg      <= '0;
      pc_reg       <= '0;
      rd1_reg      <= '0;
      flag_in_reg  <= '0;
      mem_data_reg <= '0;
      new_pc_reg   <= '0;
      flag_out_reg <= '0;
    end else begin
      pt_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (i_valid) begin
            wb_reg   <= i_WB;
            rdst_reg <= i_Rdst;
            alu_reg  <= i_alu;
            if (cur_op == OP_NONE) begin
              pt_valid_reg <= 1'b1;
            end else begin
              op_reg       <= cur_op;
              pc_op_reg    <= (word_count(cur_op, i_Mem) != 2'd1);
              flags_op_reg <= (word_count(cur_op, i_Mem) == 2'd3);
              n_reg        <= word_count(cur_op, i_Mem);
              pc_reg       <= i_pc;
              rd1_reg      <= i_read_data1;
              flag_in_reg  <= i_flag;
              k_reg        <= 2'd0;
              state_reg    <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (mem_ready) begin
            if (!mem_we) begin
              case (word)
                W_PC_HI: new_pc_reg[31:16] <= mem_rdata;
                W_PC_LO: new_pc_reg[15:0]  <= mem_rdata;
                W_FLAG:  flag_out_reg      <= mem_rdata[3:0];
                default: mem_data_reg      <= mem_rdata;
              endcase
            end
            k_reg <= k_reg + 2'd1;
            if (last_beat)
              state_reg <= DONE;
          end
        end
        // The buffer still shows the finished instruction here; ignore it.
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign o_valid     = (state_reg == DONE) || pt_valid_reg;
  assign o_pc_load   = (state_reg == DONE) && (op_reg == OP_POP) && pc_op_reg;
  assign o_flag_load = (state_reg == DONE) && (op_reg == OP_POP) && flags_op_reg;
  assign o_WB        = wb_reg;
  assign o_Rdst      = rdst_reg;
  assign o_alu       = alu_reg;
  assign o_mem_data  = mem_data_reg;
  assign o_new_pc    = new_pc_reg;
  assign o_flag      = flag_out_reg;
  assign o_sp        = sp;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage -- directed table, reset corner cases and random traffic for
// mem_stage, checked against a word-list/stack model and a memory responder.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid;
  logic [5:0]  i_Mem;
  logic [3:0]  i_WB;
  logic [2:0]  i_Rdst;
  logic [31:0] i_pc;
  logic [15:0] i_alu, i_read_data1;
  logic [3:0]  i_flag;
  logic        mem_req, mem_we, mem_ready;
  logic [19:0] mem_addr;
  logic [15:0] mem_wdata, mem_rdata;
  logic        stall, o_valid, o_pc_load, o_flag_load;
  logic [3:0]  o_WB, o_flag;
  logic [2:0]  o_Rdst;
  logic [15:0] o_alu, o_mem_data;
  logic [31:0] o_new_pc;
  logic [19:0] o_sp;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_Mem(i_Mem), .i_WB(i_WB),
    .i_Rdst(i_Rdst), .i_pc(i_pc), .i_alu(i_alu), .i_read_data1(i_read_data1),
    .i_flag(i_flag), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .stall(stall), .o_valid(o_valid), .o_WB(o_WB), .o_Rdst(o_Rdst),
    .o_alu(o_alu), .o_mem_data(o_mem_data), .o_new_pc(o_new_pc),
    .o_pc_load(o_pc_load), .o_flag(o_flag), .o_flag_load(o_flag_load), .o_sp(o_sp)
  );

  int checks = 0;
  int failures = 0;

  logic [15:0] resp_mem [logic [19:0]];  // what the DUT actually wrote
  logic [15:0] ref_mem  [logic [19:0]];  // what the model says was written
  logic [19:0] model_sp;

  logic [19:0] last_first_addr;
  logic [15:0] last_mem_data, last_alu;
  logic [31:0] last_new_pc;
  logic [3:0]  last_flag;
  logic        last_pc_load, last_flag_load;

  function automatic logic [15:0] dflt(input logic [19:0] a);
    return a[15:0] ^ 16'hA5C3;
  endfunction

  function automatic logic [15:0] resp_rd(input logic [19:0] a);
    return resp_mem.exists(a) ? resp_mem[a] : dflt(a);
  endfunction

  function automatic logic [15:0] ref_rd(input logic [19:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: event did not happen as required", name);
  endtask

  // Drive one instruction and see it through; expectations come from the
  // stack/word-list model below, memory beats are answered after 'waits' cycles.
  task automatic run_op(input logic [5:0] m, input logic [3:0] wb, input logic [2:0] rdst,
                        input logic [31:0] pc, input logic [15:0] alu, input logic [15:0] rd1,
                        input logic [3:0] flag, input int waits);
    logic [19:0] ea[$];
    logic        ewe[$];
    logic [15:0] ewd[$];
    logic [15:0] vals[$];
    logic [15:0] words[$];
    logic [19:0] a, cur_a;
    logic [15:0] cur_wd, tmpv;
    logic        cur_we;
    logic [15:0] e_data;
    logic [31:0] e_pc;
    logic [3:0]  e_flag;
    bit e_pcl, e_fl, chk_data, is_mem, done;
    int n, beat, wcnt, cyc;

    e_data = '0; e_pc = '0; e_flag = '0;
    e_pcl = 0; e_fl = 0; chk_data = 0;
    is_mem = (m[3:0] != 4'b0);

    if (m[2]) begin
      if (m[4]) begin
        words.push_back(pc[31:16]);
        words.push_back(pc[15:0]);
        if (m[5]) words.push_back({12'h000, flag});
      end else begin
        words.push_back(rd1);
      end
      foreach (words[i]) begin
        a = model_sp - 20'(i);
        ea.push_back(a); ewe.push_back(1'b1); ewd.push_back(words[i]);
        ref_mem[a] = words[i];
      end
      model_sp = model_sp - 20'(words.size());
    end else if (m[3]) begin
      n = m[4] ? (m[5] ? 3 : 2) : 1;
      for (int i = 0; i < n; i++) begin
        a = model_sp + 20'(i + 1);
        ea.push_back(a); ewe.push_back(1'b0); ewd.push_back(16'h0);
        vals.push_back(ref_rd(a));
      end
      model_sp = model_sp + 20'(n);
      if (m[4]) begin
        e_pcl = 1;
        e_fl  = m[5];
        if (m[5]) begin
          tmpv   = vals[0];
          e_flag = tmpv[3:0];
          e_pc   = {vals[2], vals[1]};
        end else begin
          e_pc = {vals[1], vals[0]};
        end
      end else begin
        chk_data = 1;
        e_data   = vals[0];
      end
    end else if (m[1]) begin
      a = {4'h0, alu};
      ea.push_back(a); ewe.push_back(1'b1); ewd.push_back(rd1);
      ref_mem[a] = rd1;
    end else if (m[0]) begin
      a = {4'h0, alu};
      ea.push_back(a); ewe.push_back(1'b0); ewd.push_back(16'h0);
      chk_data = 1;
      e_data   = ref_rd(a);
    end

    i_valid = 1'b1; i_Mem = m; i_WB = wb; i_Rdst = rdst; i_pc = pc;
    i_alu = alu; i_read_data1 = rd1; i_flag = flag;
    #1;
    chk("stall_on_accept", 32'(stall), 32'(is_mem));

    if (!is_mem) begin
      @(posedge clk); #1;
      i_valid = 1'b0;
      chk("pt_valid", 32'(o_valid), 32'd1);
      chk("pt_alu", 32'(o_alu), 32'(alu));
      chk("pt_wb", 32'(o_WB), 32'(wb));
      chk("pt_rdst", 32'(o_Rdst), 32'(rdst));
      chk("pt_no_req", 32'(mem_req), 32'd0);
      chk("pt_sp", 32'(o_sp), 32'(model_sp));
      last_alu = o_alu; last_pc_load = o_pc_load; last_flag_load = o_flag_load;
      last_mem_data = o_mem_data; last_new_pc = o_new_pc; last_flag = o_flag;
      @(posedge clk); #1;
      chk("pt_valid_pulse", 32'(o_valid), 32'd0);
    end else begin
      @(posedge clk); #1;
      beat = 0; wcnt = 0; cyc = 0; done = 0;
      cur_a = '0; cur_we = 1'b0; cur_wd = '0;
      while (!done && cyc < 200) begin
        cyc++;
        if (mem_req === 1'b1) begin
          chk("stall_access", 32'(stall), 32'd1);
          if (beat >= ea.size()) begin
            fail_now("extra_beat");
            done = 1;
          end else begin
            if (wcnt == 0) begin
              cur_a = mem_addr; cur_we = mem_we; cur_wd = mem_wdata;
              if (beat == 0) last_first_addr = mem_addr;
              chk("beat_addr", 32'(mem_addr), 32'(ea[beat]));
              chk("beat_we", 32'(mem_we), 32'(ewe[beat]));
              if (ewe[beat]) chk("beat_wdata", 32'(mem_wdata), 32'(ewd[beat]));
            end else begin
              chk("addr_stable", 32'(mem_addr), 32'(cur_a));
              chk("we_stable", 32'(mem_we), 32'(cur_we));
              chk("wdata_stable", 32'(mem_wdata), 32'(cur_wd));
            end
            mem_rdata = resp_rd(mem_addr);
            if (wcnt >= waits) begin
              mem_ready = 1'b1;
              if (mem_we) resp_mem[mem_addr] = mem_wdata;
            end
            @(posedge clk); #1;
            if (mem_ready) begin
              mem_ready = 1'b0;
              beat++;
              wcnt = 0;
            end else begin
              wcnt++;
            end
          end
        end else if (o_valid === 1'b1) begin
          chk("beats", 32'(beat), 32'(ea.size()));
          chk("stall_done", 32'(stall), 32'd0);
          chk("done_wb", 32'(o_WB), 32'(wb));
          chk("done_rdst", 32'(o_Rdst), 32'(rdst));
          chk("done_alu", 32'(o_alu), 32'(alu));
          chk("done_pc_load", 32'(o_pc_load), 32'(e_pcl));
          chk("done_flag_load", 32'(o_flag_load), 32'(e_fl));
          if (e_pcl) chk("done_new_pc", o_new_pc, e_pc);
          if (e_fl) chk("done_flag", 32'(o_flag), 32'(e_flag));
          if (chk_data) chk("done_mem_data", 32'(o_mem_data), 32'(e_data));
          chk("done_sp", 32'(o_sp), 32'(model_sp));
          last_alu = o_alu; last_pc_load = o_pc_load; last_flag_load = o_flag_load;
          last_mem_data = o_mem_data; last_new_pc = o_new_pc; last_flag = o_flag;
          done = 1;
          @(posedge clk); #1;
          i_valid = 1'b0;
          chk("done_valid_pulse", 32'(o_valid), 32'd0);
          chk("done_load_pulse", 32'(o_pc_load | o_flag_load), 32'd0);
        end else begin
          fail_now("no_progress");
          done = 1;
        end
      end
      if (!done) fail_now("timeout");
    end
    $display("txn m=%b alu=%h rd1=%h pc=%h flag=%h waits=%0d sp_after=%h",
             m, alu, rd1, pc, flag, waits, o_sp);
  endtask

  typedef struct {
    logic [5:0]  m;
    logic [15:0] alu;
    logic [15:0] rd1;
    logic [31:0] pc;
    logic [3:0]  flag;
    int          waits;
    logic [19:0] e_addr0;
    logic [19:0] e_sp;
    logic        e_chk_data;
    logic [15:0] e_data;
    logic        e_pcl;
    logic [31:0] e_pc;
    logic        e_fl;
    logic [3:0]  e_flag;
  } vec_t;

  vec_t tv[15];

  initial begin
    logic [5:0]  m;
    logic [19:0] a0;
    int kind;

    tv[0]  = '{6'b000000, 16'h1234, 16'h0000, 32'h0,        4'h0, 0, 20'h00000, 20'hFFFFF, 1'b0, 16'h0000, 1'b0, 32'h0,        1'b0, 4'h0};
    tv[1]  = '{6'b000010, 16'h0010, 16'hBEEF, 32'h0,        4'h0, 2, 20'h00010, 20'hFFFFF, 1'b0, 16'h0000, 1'b0, 32'h0,        1'b0, 4'h0};
    tv[2]  = '{6'b000001, 16'h0010, 16'h0000, 32'h0,        4'h0, 1, 20'h00010, 20'hFFFFF, 1'b1, 16'hBEEF, 1'b0, 32'h0,        1'b0, 4'h0};
    tv[3]  = '{6'b110100, 16'h0003, 16'h0000, 32'hAABBCCDD, 4'hA, 1, 20'hFFFFF, 20'hFFFFC, 1'b0, 16'h0000, 1'b0, 32'h0,        1'b0, 4'h0};
    tv[4]  = '{6'b111000, 16'h0004, 16'h0000, 32'h0,        4'h0, 0, 20'hFFFFD, 20'hFFFFF, 1'b0, 16'h0000, 1'b1, 32'hAABBCCDD, 1'b1, 4'hA};
    tv[5]  = '{6'b001000, 16'h0005, 16'h0000, 32'h0,        4'h0, 1, 20'h00000, 20'h00000, 1'b1, 16'hA5C3, 1'b0, 32'h0,        1'b0, 4'h0};
    tv[6]  = '{6'b000100, 16'h0006, 16'h1357, 32'h0,        4'h0, 0, 20'h00000, 20'hFFFFF, 1'b0, 16'h0000, 1'b0, 32'h0,        1'b0, 4'h0};
    tv[7]  = '{6'b001000, 16'h0007, 16'h0000, 32'h0,        4'h0, 0, 20'h00000, 20'h00000, 1'b1, 16'h1357, 1'b0, 32'h0,        1'b0, 4'h0};
    tv[8]  = '{6'b100000, 16'h5555, 16'h0000, 32'h0,        4'h0, 0, 20'h00000, 20'h00000, 1'b0, 16'h0000, 1'b0, 32'h0,        1'b0, 4'h0};
    tv[9]  = '{6'b010100, 16'h0009, 16'h0000, 32'h12345678, 4'h0, 2, 20'h00000, 20'hFFFFE, 1'b0, 16'h0000, 1'b0, 32'h0,        1'b0, 4'h0};
    tv[10] = '{6'b011000, 16'h000A, 16'h0000, 32'h0,        4'h0, 1, 20'hFFFFF, 20'h00000, 1'b0, 16'h0000, 1'b1, 32'h12345678, 1'b0, 4'h0};
    tv[11] = '{6'b001111, 16'h000B, 16'h2468, 32'h0,        4'h0, 0, 20'h00000, 20'hFFFFF, 1'b0, 16'h0000, 1'b0, 32'h0,        1'b0, 4'h0};
    tv[12] = '{6'b000011, 16'h0020, 16'h7777, 32'h0,        4'h0, 1, 20'h00020, 20'hFFFFF, 1'b0, 16'h0000, 1'b0, 32'h0,        1'b0, 4'h0};
    tv[13] = '{6'b000001, 16'h0020, 16'h0000, 32'h0,        4'h0, 0, 20'h00020, 20'hFFFFF, 1'b1, 16'h7777, 1'b0, 32'h0,        1'b0, 4'h0};
    tv[14] = '{6'b001000, 16'h000E, 16'h0000, 32'h0,        4'h0, 3, 20'h00000, 20'h00000, 1'b1, 16'h2468, 1'b0, 32'h0,        1'b0, 4'h0};

    // Reset with a memory op pending on the inputs: everything stays quiet.
    rst = 1'b1; i_valid = 1'b1; i_Mem = 6'b000100; i_WB = 4'h0; i_Rdst = 3'h0;
    i_pc = '0; i_alu = 16'h0; i_read_data1 = 16'h0; i_flag = 4'h0;
    mem_ready = 1'b0; mem_rdata = 16'h0;
    #1 rst = 1'b0;
    #1;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_sp", 32'(o_sp), 32'h000FFFFF);
    chk("rst_loads", 32'(o_pc_load | o_flag_load), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_alu", 32'(o_alu), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_req", 32'(mem_req), 32'd0);
    rst = 1'b1; i_valid = 1'b0;
    model_sp = 20'hFFFFF;

    // Directed vector table.
    for (int i = 0; i < 15; i++) begin
      run_op(tv[i].m, 4'(i), 3'(i), tv[i].pc, tv[i].alu, tv[i].rd1, tv[i].flag, tv[i].waits);
      if (tv[i].m[3:0] != 4'b0) chk("tbl_addr0", 32'(last_first_addr), 32'(tv[i].e_addr0));
      chk("tbl_sp", 32'(o_sp), 32'(tv[i].e_sp));
      chk("tbl_alu", 32'(last_alu), 32'(tv[i].alu));
      chk("tbl_pc_load", 32'(last_pc_load), 32'(tv[i].e_pcl));
      chk("tbl_flag_load", 32'(last_flag_load), 32'(tv[i].e_fl));
      if (tv[i].e_chk_data) chk("tbl_data", 32'(last_mem_data), 32'(tv[i].e_data));
      if (tv[i].e_pcl) chk("tbl_new_pc", last_new_pc, tv[i].e_pc);
      if (tv[i].e_fl) chk("tbl_flag", 32'(last_flag), 32'(tv[i].e_flag));
    end

    // Randomized traffic against the model.
    for (int r = 0; r < 40; r++) begin
      kind = $urandom_range(0, 4);
      case (kind)
        0: m = {2'($urandom_range(0, 3)), 4'b0000};
        1: m = 6'b000001;
        2: m = 6'b000010;
        3: m = {2'($urandom_range(0, 3)), 4'b0100};
        default: m = {2'($urandom_range(0, 3)), 4'b1000};
      endcase
      run_op(m, 4'($urandom), 3'($urandom), $urandom, 16'($urandom_range(0, 31)),
             16'($urandom), 4'($urandom), int'($urandom_range(0, 3)));
    end

    // Reset during word 1 of a pc+flags push.
    i_valid = 1'b1; i_Mem = 6'b110100; i_pc = 32'hDEADBEEF; i_flag = 4'h5;
    i_read_data1 = 16'h0; i_alu = 16'h0;
    @(posedge clk); #1;
    chk("rs_req_w0", 32'(mem_req), 32'd1);
    chk("rs_addr_w0", 32'(mem_addr), 32'(model_sp));
    a0 = mem_addr;
    mem_ready = 1'b1;
    resp_mem[a0] = mem_wdata;
    ref_mem[a0] = 16'hDEAD;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    chk("rs_req_w1", 32'(mem_req), 32'd1);
    chk("rs_addr_w1", 32'(mem_addr), 32'(model_sp - 20'd1));
    #2 rst = 1'b0;
    #1;
    chk("rs_req_drop", 32'(mem_req), 32'd0);
    chk("rs_stall_drop", 32'(stall), 32'd0);
    chk("rs_valid", 32'(o_valid), 32'd0);
    chk("rs_sp", 32'(o_sp), 32'h000FFFFF);
    model_sp = 20'hFFFFF;
    @(posedge clk); #1;
    i_valid = 1'b0;
    rst = 1'b1;

    // A stray ready with no request must do nothing.
    mem_ready = 1'b1; mem_rdata = 16'hFFFF;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    chk("stray_ready_valid", 32'(o_valid), 32'd0);
    chk("stray_ready_req", 32'(mem_req), 32'd0);
    chk("stray_ready_sp", 32'(o_sp), 32'h000FFFFF);

    // Next operations start cleanly from IDLE at the reset SP.
    run_op(6'b000100, 4'h3, 3'h5, 32'h0, 16'h0001, 16'h4242, 4'h0, 1);
    chk("post_rs_addr0", 32'(last_first_addr), 32'h000FFFFF);
    run_op(6'b001000, 4'h2, 3'h1, 32'h0, 16'h0002, 16'h0000, 4'h0, 0);
    chk("post_rs_pop", 32'(last_mem_data), 32'h00004242);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have clk  in  1  single clock; all state on rising edge.
REQ-002 SHALL have rst  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have i_valid  in  1  buffer output holds a valid instruction.
REQ-004 SHALL have i_Mem  in  6  [0]read [1]write [2]push [3]pop [4]pc (32-bit PC transfer) [5]flags (with pc only).
REQ-005 SHALL have i_WB  in  4, i_Rdst  in  3, i_pc  in  32, i_alu  in  16, i_read_data1  in  16, i_flag  in  4; these are the ALU/MEM buffer outputs.
REQ-006 SHALL have mem_req  out  1, mem_we  out  1, mem_addr  out  20, mem_wdata  out  16, mem_rdata  in  16, mem_ready  in  1; this is the data-memory port.
REQ-007 SHALL have stall  out  1; freezes upstream buffer enables.
REQ-008 SHALL have o_valid  out  1, o_WB  out  4, o_Rdst  out  3, o_alu  out  16, o_mem_data  out  16; these feed writeback.
REQ-009 SHALL have o_new_pc  out  32, o_pc_load  out  1, o_flag  out  4, o_flag_load  out  1, o_sp  out  20.

Function
REQ-010 SHALL decode one op per instruction, priority push > pop > write > read; i_Mem[3:0]==0 means pass-through.
REQ-011 SHALL use word count n = 1 for plain ops, 2 for pc, and 3 for pc+flags; i_Mem[5] without [4] SHALL be ignored.
REQ-012 SHALL have FSM states IDLE, ACCESS, DONE, with a 2-bit word index k.
REQ-013 IDLE: i_valid with a memory op latches all inputs and sets k=0, then goes to ACCESS; i_valid with a pass-through op registers its fields with o_valid=1 next cycle (1-cycle latency).
REQ-014 ACCESS: SHALL hold mem_req=1 with addr/we/wdata stable until mem_ready; on mem_ready, k++ and the SP steps; after word n-1 it goes to DONE.
REQ-015 DONE: o_valid=1 for exactly one cycle, then goes to IDLE.
REQ-016 stall SHALL equal (state==ACCESS) | (state==IDLE & i_valid & memory op); stall SHALL be 0 in DONE.
REQ-017 read/write SHALL use addr = {4'b0,i_alu}; write data SHALL be i_read_data1; read data SHALL go to o_mem_data.
REQ-018 push words SHALL be, in order: pc[31:16] @SP, pc[15:0] @SP-1, {12'b0,flag} @SP-2; a plain push SHALL write i_read_data1 @SP; the SP decrements per word.
REQ-019 pop SHALL pre-increment the SP per word; order SHALL be flags (if [5]), pc[15:0], pc[31:16]; a plain pop SHALL go to o_mem_data.
REQ-020 in DONE, a pc pop SHALL assert o_pc_load=1 with o_new_pc; a flags pop SHALL assert o_flag_load=1 with o_flag; each is a one-cycle pulse.
REQ-021 SP arithmetic SHALL be modulo 2^20: FFFFF+1 wraps to 00000 and 00000-1 wraps to FFFFF, with no error flag.
REQ-022 mem_ready while mem_req=0 SHALL be ignored; wait states SHALL be unbounded.
REQ-023 o_WB, o_Rdst, o_alu SHALL carry latched values in DONE.

Reset
REQ-024 rst low SHALL immediately force state IDLE, k=0, and SP=20'hFFFFF.
REQ-025 rst low SHALL immediately force mem_req, mem_we, stall, o_valid, o_pc_load, o_flag_load to 0; data outputs SHALL be 0.
REQ-026 reset mid-ACCESS SHALL abandon the transfer; partial SP steps are discarded.

Structure
REQ-027 mem_stage_pkg SHALL hold the state enum, i_Mem bit indices, ADDR_W=20, and SP_RESET=20'hFFFFF.
REQ-028 the SP register and its +/-1 logic SHALL be sub-module stack_ptr (inc, dec, value).

Verification
REQ-029 pass-through i_Mem=0, i_alu=16'h1234 -> o_valid=1 with o_alu=1234 next cycle; stall=0.
REQ-030 write i_alu=16'h0010, data 16'hBEEF, mem_ready after 2 waits -> mem_addr 00010 stable for 3 cycles; stall high throughout; DONE one cycle.
REQ-031 push pc+flags with i_pc=32'hAABBCCDD, i_flag=4'b1010 from reset -> writes AABB@FFFFF, CCDD@FFFFE, 000A@FFFFD; o_sp=FFFFC.
REQ-032 matching pop afterwards -> reads FFFFD, FFFFE, FFFFF; o_new_pc=AABBCCDD, o_flag=1010 with load pulses; o_sp=FFFFF.
REQ-033 pop with SP=FFFFF -> reads address 00000; o_sp=00000 (wrap).
REQ-034 rst asserted during word 1 of a pc push -> mem_req drops immediately; o_sp=FFFFF; next op starts from IDLE.
